// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
// Shared definitions for the 2-input gate sweep sequencer:
//   - state encodings and the FSM state type
//   - number of input combinations swept (NUM_COMBOS)
//   - largest supported settle time (SETTLE_MAX)
package gate_sweep_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_SETTLE = 2'd1;
  localparam logic [1:0] STATE_SAMPLE = 2'd2;
  localparam logic [1:0] STATE_DONE   = 2'd3;

  localparam int NUM_COMBOS = 4;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_SETTLE = STATE_SETTLE,
    ST_SAMPLE = STATE_SAMPLE,
    ST_DONE   = STATE_DONE
  } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer
// 4-bit down-counter that times how long each input combination is held.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset (count -> 0)
//   load_i     load load_val_i into the counter (has priority over en_i)
//   load_val_i value to load
//   en_i       decrement by one this cycle
//   zero_o     count is currently zero
module sweep_settle_timer
  import gate_sweep_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// Steps a 2-input gate through combinations 00,01,10,11 ({a,b}), holds each
// for SETTLE cycles, samples the gate output for one cycle and builds a
// 4-bit truth table, which is compared against an expected table latched
// when the sweep is accepted.
// Parameters:
//   SETTLE     hold cycles per combination, 1..15 (out-of-range is clamped)
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      request a sweep (only looked at in IDLE)
//   abort      cancel a running sweep on the next edge
//   expected   expected truth table, bit i = output for combination i
//   gate_a/b   gate input drives (idx[1], idx[0] while busy)
//   gate_s     gate output under test
//   busy       sweep in progress
//   done       one-cycle completion pulse
//   pass       table_out matches latched expected (held until next start)
//   table_out  captured truth table
//   fail_mask  table_out XOR latched expected
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] table_out,
  output logic [3:0] fail_mask
);

  // Clamp to the range the 4-bit timer can represent.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 :
                              ((SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE);
  // The timer counts down to zero inclusive, so SETTLE-1 gives SETTLE cycles.
  localparam logic [3:0] RELOAD = 4'(SETTLE_EFF - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_COMBOS - 1);

  sweep_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [3:0]   exp_q, exp_d;
  logic [3:0]   table_q, table_d;
  logic [3:0]   fail_q, fail_d;
  logic         pass_q, pass_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_zero;

  sweep_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    table_d  = table_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort beats start so a cancel request can never launch a sweep.
        if (start && !abort) begin
          exp_d    = expected;
          table_d  = 4'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // Partial table is kept; the current combination is not captured.
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          table_d[idx_q] = gate_s;
          if (idx_q == LAST_IDX) begin
            // Verdict is registered on the way into DONE so it is valid
            // in the same cycle as the done pulse.
            fail_d  = table_d ^ exp_q;
            pass_d  = (table_d == exp_q);
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + 2'd1;
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      exp_q   <= 4'd0;
      table_q <= 4'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign gate_a    = busy & idx_q[1];
  assign gate_b    = busy & idx_q[0];
  assign pass      = pass_q;
  assign table_out = table_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed testbench for gate_sweep_ctrl. Two instances: SETTLE=1 driving an
// (~a | b) gate and SETTLE=3 driving a NOR gate. Inputs change on negedge,
// outputs are checked on negedge.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance 1: SETTLE=1, gate = ~a | b  (truth table 4'b1011)
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [3:0] exp1 = 4'd0;
  logic       ga1, gb1, gs1, busy1, done1, pass1;
  logic [3:0] tbl1, fm1;

  // Instance 2: SETTLE=3, gate = NOR  (truth table 4'b0001)
  logic       start2 = 1'b0, abort2 = 1'b0;
  logic [3:0] exp2 = 4'd0;
  logic       ga2, gb2, gs2, busy2, done2, pass2;
  logic [3:0] tbl2, fm2;

  int n_tests = 0;
  int n_fail  = 0;

  assign gs1 = ~ga1 | gb1;
  assign gs2 = ~(ga2 | gb2);

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(exp1), .gate_a(ga1), .gate_b(gb1), .gate_s(gs1),
    .busy(busy1), .done(done1), .pass(pass1),
    .table_out(tbl1), .fail_mask(fm1)
  );

  gate_sweep_ctrl #(.SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .expected(exp2), .gate_a(ga2), .gate_b(gb2), .gate_s(gs2),
    .busy(busy2), .done(done2), .pass(pass2),
    .table_out(tbl2), .fail_mask(fm2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %-24s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nedges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start on instance 1 for one edge; returns at negedge 1 after edge k.
  task automatic go1(input logic [3:0] e);
    exp1 = e; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic go2(input logic [3:0] e);
    exp2 = e; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    nedges(2);
    chk("rst_busy1", {7'd0, busy1}, 8'd0);
    chk("rst_outs1", {ga1, gb1, done1, pass1, tbl1}, 8'd0);
    chk("rst_fm1", {4'd0, fm1}, 8'd0);
    chk("rst_outs2", {ga2, gb2, busy2, done2, tbl2}, 8'd0);
    rst_n = 1'b1;
    nedges(1);

    // ---------------- T1: SETTLE=1, ~a|b, expected 1011 ----------------
    go1(4'b1011);                              // now at n=1
    chk("t1_n1_busy", {7'd0, busy1}, 8'd1);
    chk("t1_n1_gate", {6'd0, ga1, gb1}, 8'b00);
    nedges(2);                                 // n=3
    chk("t1_n3_gate", {6'd0, ga1, gb1}, 8'b01);
    chk("t1_n3_tbl", {4'd0, tbl1}, 8'b0001);
    exp1 = 4'b0000;                            // ignored while busy
    nedges(2);                                 // n=5
    chk("t1_n5_gate", {6'd0, ga1, gb1}, 8'b10);
    nedges(2);                                 // n=7
    chk("t1_n7_gate", {6'd0, ga1, gb1}, 8'b11);
    nedges(1);                                 // n=8
    chk("t1_n8_done", {7'd0, done1}, 8'd0);
    nedges(1);                                 // n=9
    chk("t1_n9_done", {6'd0, done1, busy1}, 8'b10);
    chk("t1_tbl", {4'd0, tbl1}, 8'b1011);
    chk("t1_pass", {7'd0, pass1}, 8'd1);
    chk("t1_fm", {4'd0, fm1}, 8'd0);
    chk("t1_dn_gate", {6'd0, ga1, gb1}, 8'b00);
    nedges(1);                                 // n=10, IDLE
    chk("t1_n10_hold", {2'd0, done1, pass1, tbl1}, {2'd0, 1'b0, 1'b1, 4'b1011});

    // ---------------- T6: back-to-back, expected 0100 ----------------
    go1(4'b0100);                              // n=1
    chk("t6_clr", {3'd0, pass1, tbl1}, 8'd0);
    nedges(8);                                 // n=9
    chk("t6_done", {7'd0, done1}, 8'd1);
    chk("t6_tbl", {4'd0, tbl1}, 8'b1011);
    chk("t6_pass", {7'd0, pass1}, 8'd0);
    chk("t6_fm", {4'd0, fm1}, 8'b1111);
    nedges(1);

    // ---------------- T2: SETTLE=3, NOR, expected 1011 ----------------
    go2(4'b1011);                              // n=1
    nedges(3);                                 // n=4 (comb 0 SAMPLE)
    chk("t2_n4_gate", {6'd0, ga2, gb2}, 8'b00);
    nedges(1);                                 // n=5
    chk("t2_n5_gate", {6'd0, ga2, gb2}, 8'b01);
    nedges(11);                                // n=16
    chk("t2_n16_done", {6'd0, done2, busy2}, 8'b01);
    nedges(1);                                 // n=17
    chk("t2_n17_done", {6'd0, done2, busy2}, 8'b10);
    chk("t2_tbl", {4'd0, tbl2}, 8'b0001);
    chk("t2_pass", {7'd0, pass2}, 8'd0);
    chk("t2_fm", {4'd0, fm2}, 8'b1010);
    nedges(1);

    // ---------------- T3: abort in combination 2 SAMPLE ----------------
    go1(4'b1011);                              // n=1
    nedges(5);                                 // n=6, comb 2 SAMPLE
    chk("t3_pre_gate", {6'd0, ga1, gb1}, 8'b10);
    abort1 = 1'b1;
    nedges(1);                                 // n=7
    abort1 = 1'b0;
    chk("t3_busy", {6'd0, busy1, done1}, 8'b00);
    chk("t3_gate", {6'd0, ga1, gb1}, 8'b00);
    chk("t3_tbl", {4'd0, tbl1}, 8'b0011);
    chk("t3_pass", {7'd0, pass1}, 8'd0);
    nedges(3);
    chk("t3_nodone", {6'd0, busy1, done1}, 8'b00);

    // abort together with start in IDLE: no sweep
    start1 = 1'b1; abort1 = 1'b1; exp1 = 4'b1011;
    nedges(1);
    start1 = 1'b0; abort1 = 1'b0;
    chk("t3_abort_start", {6'd0, busy1, done1}, 8'b00);
    nedges(1);

    // ---------------- T4: start held high, expected changed ----------------
    exp1 = 4'b1011; start1 = 1'b1;
    nedges(1);                                 // n=1
    nedges(2);                                 // n=3
    exp1 = 4'b0000;
    chk("t4_n3_busy", {7'd0, busy1}, 8'd1);
    nedges(6);                                 // n=9
    chk("t4_done", {7'd0, done1}, 8'd1);
    chk("t4_pass", {7'd0, pass1}, 8'd1);
    nedges(1);                                 // n=10: IDLE, start ignored in DONE
    chk("t4_idle", {6'd0, busy1, done1}, 8'b00);
    nedges(1);                                 // n=11: new sweep accepted
    chk("t4_restart", {7'd0, busy1}, 8'd1);
    chk("t4_restart_clr", {7'd0, pass1}, 8'd0);
    start1 = 1'b0; abort1 = 1'b1;
    nedges(1);
    abort1 = 1'b0;
    chk("t4_stop", {7'd0, busy1}, 8'd0);

    // ---------------- T5: async reset mid-SETTLE ----------------
    go2(4'b0001);                              // n=1
    nedges(4);                                 // n=5, comb 1 SETTLE
    chk("t5_pre", {6'd0, busy2, gb2}, 8'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", {6'd0, busy2, busy1}, 8'b00);
    chk("t5_async_outs", {ga2, gb2, done2, pass2, tbl2}, 8'd0);
    nedges(1);
    rst_n = 1'b1;
    nedges(1);
    go2(4'b0001);                              // n=1
    nedges(16);                                // n=17
    chk("t5_done", {7'd0, done2}, 8'd1);
    chk("t5_tbl", {4'd0, tbl2}, 8'b0001);
    chk("t5_pass", {3'd0, pass2, fm2}, 8'b1_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
